load_store_unit: RTL and testbench

- Memory stage directly downstream of the ALU wrapper.
- Consumes the ALU result as the effective address, together with the store data and control decoded upstream.
- Runs single byte/halfword/word loads and stores, and Thumb multiple-register transfers (LDM/STM), over a req/ready data-memory handshake.
- Produces register writeback beats and a pipeline stall.

---
 rtl/load_store_unit_pkg.sv | 29 ++
 rtl/load_store_unit_if.sv | 43 ++++
 rtl/load_store_unit_mem_lane_align.sv | 50 +++++
 rtl/load_store_unit.sv | 174 +++++++++++++++++
 tb/tb_load_store_unit.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: operation and size encodings, FSM states.
package load_store_unit_pkg;
    localparam int WORD       = 32;
    localparam int BYTE_LANES = 4;

    typedef enum logic [2:0] {
        MEM_NONE,
        MEM_LOAD,
        MEM_STORE,
        MEM_LOAD_MULT,
        MEM_STORE_MULT
    } mem_op_t;

    typedef enum logic [1:0] {
        SIZE_BYTE,
        SIZE_HALF,
        SIZE_WORD
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE,
        SINGLE,
        MULT
    } lsu_state_t;

    function automatic logic is_mult(input mem_op_t op);
        return (op == MEM_LOAD_MULT) || (op == MEM_STORE_MULT);
    endfunction
endpackage

// File: rtl/load_store_unit_if.sv
// EX-side, register-file, data-memory and writeback signals of the load/store unit.
interface load_store_unit_if #(
    parameter int ADDR_W     = 32,
    parameter int REG_LIST_W = 8
);
    import load_store_unit_pkg::*;

    logic                  ex_valid_i;
    mem_op_t               mem_op_i;
    mem_size_t             mem_size_i;
    logic                  sign_ext_i;
    logic [ADDR_W-1:0]     address_i;
    logic [WORD-1:0]       store_data_i;
    logic [3:0]            dest_reg_i;
    logic [REG_LIST_W-1:0] reg_list_i;
    logic [3:0]            rf_read_reg_o;
    logic [WORD-1:0]       rf_read_data_i;
    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [ADDR_W-1:0]     mem_addr_o;
    logic [BYTE_LANES-1:0] mem_byte_en_o;
    logic [WORD-1:0]       mem_wdata_o;
    logic                  mem_ready_i;
    logic [WORD-1:0]       mem_rdata_i;
    logic                  wb_valid_o;
    logic [3:0]            wb_reg_o;
    logic [WORD-1:0]       wb_data_o;
    logic                  stall_o;

    modport slave (
        input  ex_valid_i, mem_op_i, mem_size_i, sign_ext_i, address_i, store_data_i,
               dest_reg_i, reg_list_i, rf_read_data_i, mem_ready_i, mem_rdata_i,
        output rf_read_reg_o, mem_req_o, mem_we_o, mem_addr_o, mem_byte_en_o,
               mem_wdata_o, wb_valid_o, wb_reg_o, wb_data_o, stall_o
    );

    modport master (
        output ex_valid_i, mem_op_i, mem_size_i, sign_ext_i, address_i, store_data_i,
               dest_reg_i, reg_list_i, rf_read_data_i, mem_ready_i, mem_rdata_i,
        input  rf_read_reg_o, mem_req_o, mem_we_o, mem_addr_o, mem_byte_en_o,
               mem_wdata_o, wb_valid_o, wb_reg_o, wb_data_o, stall_o
    );
endinterface

// File: rtl/load_store_unit_mem_lane_align.sv
// Byte-lane steering: store-side enables/replication, load-side lane pick and extension.
module mem_lane_align
    import load_store_unit_pkg::*;
(
    input  mem_size_t             i_size,
    input  logic [1:0]            i_addr_lo,
    input  logic                  i_sign_ext,
    input  logic [WORD-1:0]       i_st_data,
    input  logic [WORD-1:0]       i_ld_data,
    output logic [BYTE_LANES-1:0] o_byte_en,
    output logic [WORD-1:0]       o_wdata,
    output logic [WORD-1:0]       o_ld_data
);
    logic [BYTE_LANES-1:0][7:0] w_rd_lanes;
    logic [BYTE_LANES-1:0][7:0] w_wr_lanes;
    logic [7:0]                 w_byte;
    logic [15:0]                w_half;

    assign w_rd_lanes = i_ld_data;
    assign o_wdata    = w_wr_lanes;

    // Each lane takes the byte of the store datum that lands on it after replication.
    for (genvar g = 0; g < BYTE_LANES; g++) begin : g_lane
        always_comb begin
            case (i_size)
                SIZE_BYTE: w_wr_lanes[g] = i_st_data[7:0];
                SIZE_HALF: w_wr_lanes[g] = i_st_data[8*(g%2) +: 8];
                default:   w_wr_lanes[g] = i_st_data[8*g +: 8];
            endcase
        end
    end

    always_comb begin
        case (i_size)
            SIZE_BYTE: o_byte_en = 4'b0001 << i_addr_lo;
            SIZE_HALF: o_byte_en = 4'b0011 << {i_addr_lo[1], 1'b0};
            default:   o_byte_en = 4'b1111;
        endcase
    end

    always_comb begin
        w_byte = w_rd_lanes[i_addr_lo];
        w_half = i_addr_lo[1] ? i_ld_data[31:16] : i_ld_data[15:0];
        case (i_size)
            SIZE_BYTE: o_ld_data = {{24{i_sign_ext & w_byte[7]}}, w_byte};
            SIZE_HALF: o_ld_data = {{16{i_sign_ext & w_half[15]}}, w_half};
            default:   o_ld_data = i_ld_data;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Memory stage: single loads/stores and LDM/STM over a req/ready data port.
// Build with MEM_ALIGN_CHECK_EN to trap misaligned accesses on align_fault_o.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int REG_LIST_W = 8
) (
    input  logic clk_i,
    input  logic reset_i,
    load_store_unit_if.slave bus
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic align_fault_o
`endif
);
    lsu_state_t            r_state, w_next;
    mem_op_t               r_op;
    mem_size_t             r_size;
    logic                  r_sext;
    logic [ADDR_W-1:0]     r_addr;
    logic [WORD-1:0]       r_st_data;
    logic [3:0]            r_dest;
    logic [REG_LIST_W-1:0] r_list;
    logic [3:0]            r_beats;
    logic                  r_wb_valid;
    logic [3:0]            r_wb_reg;
    logic [WORD-1:0]       r_wb_data;

    logic                  w_busy, w_capture, w_beat, w_misalign;
    logic [3:0]            w_cur_idx;
    logic [REG_LIST_W-1:0] w_cur_bit, w_list_rem;
    logic [ADDR_W-1:0]     w_base, w_mult_addr;
    logic [BYTE_LANES-1:0] w_be;
    logic [WORD-1:0]       w_wdata, w_ld_data;

    assign w_busy    = (r_state != IDLE);
    assign w_capture = (r_state == IDLE) && bus.ex_valid_i && (bus.mem_op_i != MEM_NONE);
    assign w_beat    = w_busy && bus.mem_ready_i;

`ifdef MEM_ALIGN_CHECK_EN
    logic r_fault;

    always_comb begin
        w_misalign = 1'b0;
        if (is_mult(bus.mem_op_i))
            w_misalign = (bus.address_i[1:0] != 2'b00);
        else if (bus.mem_size_i == SIZE_HALF)
            w_misalign = bus.address_i[0];
        else if (bus.mem_size_i == SIZE_WORD)
            w_misalign = (bus.address_i[1:0] != 2'b00);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) r_fault <= 1'b0;
        else         r_fault <= w_capture && w_misalign;
    end

    assign align_fault_o = r_fault;
`else
    assign w_misalign = 1'b0;
`endif

    always_comb begin
        w_cur_idx = 4'd0;
        for (int i = REG_LIST_W - 1; i >= 0; i--)
            if (r_list[i]) w_cur_idx = 4'(i);
    end

    assign w_cur_bit   = r_list & (~r_list + REG_LIST_W'(1));
    assign w_list_rem  = r_list & ~w_cur_bit;
    assign w_base      = {r_addr[ADDR_W-1:2], 2'b00};
    assign w_mult_addr = w_base + {{(ADDR_W-6){1'b0}}, r_beats, 2'b00};

    mem_lane_align u_align (
        .i_size    (r_size),
        .i_addr_lo (r_addr[1:0]),
        .i_sign_ext(r_sext),
        .i_st_data (r_st_data),
        .i_ld_data (bus.mem_rdata_i),
        .o_byte_en (w_be),
        .o_wdata   (w_wdata),
        .o_ld_data (w_ld_data)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_capture && !w_misalign) begin
                    if (!is_mult(bus.mem_op_i))  w_next = SINGLE;
                    else if (|bus.reg_list_i)    w_next = MULT;
                end
            end
            SINGLE:  if (bus.mem_ready_i) w_next = IDLE;
            MULT:    if (bus.mem_ready_i && (w_list_rem == '0)) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_op       <= MEM_NONE;
            r_size     <= SIZE_BYTE;
            r_sext     <= 1'b0;
            r_addr     <= '0;
            r_st_data  <= '0;
            r_dest     <= '0;
            r_list     <= '0;
            r_beats    <= '0;
            r_wb_valid <= 1'b0;
            r_wb_reg   <= '0;
            r_wb_data  <= '0;
        end else begin
            r_wb_valid <= 1'b0;
            if (w_capture) begin
                r_op      <= bus.mem_op_i;
                r_size    <= bus.mem_size_i;
                r_sext    <= bus.sign_ext_i;
                r_addr    <= bus.address_i;
                r_st_data <= bus.store_data_i;
                r_dest    <= bus.dest_reg_i;
                r_list    <= is_mult(bus.mem_op_i) ? bus.reg_list_i : '0;
                r_beats   <= '0;
            end
            if (w_beat && (r_state == SINGLE) && (r_op == MEM_LOAD)) begin
                r_wb_valid <= 1'b1;
                r_wb_reg   <= r_dest;
                r_wb_data  <= w_ld_data;
            end
            if (w_beat && (r_state == MULT)) begin
                r_list  <= w_list_rem;
                r_beats <= r_beats + 4'd1;
                if (r_op == MEM_LOAD_MULT) begin
                    r_wb_valid <= 1'b1;
                    r_wb_reg   <= w_cur_idx;
                    r_wb_data  <= bus.mem_rdata_i;
                end
            end
        end
    end

    always_comb begin
        bus.mem_addr_o    = '0;
        bus.mem_byte_en_o = '0;
        bus.mem_wdata_o   = '0;
        case (r_state)
            SINGLE: begin
                bus.mem_addr_o    = w_base;
                bus.mem_byte_en_o = w_be;
                bus.mem_wdata_o   = w_wdata;
            end
            MULT: begin
                bus.mem_addr_o    = w_mult_addr;
                bus.mem_byte_en_o = 4'b1111;
                bus.mem_wdata_o   = (r_op == MEM_STORE_MULT) ? bus.rf_read_data_i : '0;
            end
            default: ;
        endcase
    end

    assign bus.rf_read_reg_o = w_cur_idx;
    assign bus.mem_req_o     = w_busy;
    assign bus.mem_we_o      = w_busy && ((r_op == MEM_STORE) || (r_op == MEM_STORE_MULT));
    assign bus.stall_o       = w_busy;
    assign bus.wb_valid_o    = r_wb_valid;
    assign bus.wb_reg_o      = r_wb_reg;
    assign bus.wb_data_o     = r_wb_data;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a beat/writeback scoreboard.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        chk_rr;
        logic [3:0]  rr;
    } beat_t;

    typedef struct packed {
        logic [3:0]  r;
        logic [31:0] d;
    } wb_t;

    logic clk, rst;
    int   total = 0;
    int   bad   = 0;
    int   wait_cfg = 0;
    beat_t beat_q[$];
    wb_t   wb_q[$];
    logic [31:0] rf [16];

    load_store_unit_if bus ();

`ifdef MEM_ALIGN_CHECK_EN
    logic align_fault;
`endif

    load_store_unit dut (
        .clk_i  (clk),
        .reset_i(rst),
        .bus    (bus.slave)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .align_fault_o(align_fault)
`endif
    );

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return (a == 32'h0000_1000) ? 32'h80FF_FFFF : (a ^ 32'hDEAD_0000);
    endfunction

    assign bus.mem_rdata_i    = rdata_of(bus.mem_addr_o);
    assign bus.rf_read_data_i = rf[bus.rf_read_reg_o];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_beat(input logic [31:0] a, input logic we, input logic [3:0] be,
                             input logic [31:0] wd, input logic chk_rr, input logic [3:0] rr);
        beat_t b;
        b.addr = a; b.we = we; b.be = be; b.wd = wd; b.chk_rr = chk_rr; b.rr = rr;
        beat_q.push_back(b);
    endtask

    task automatic push_wb(input logic [3:0] r, input logic [31:0] d);
        wb_t w;
        w.r = r; w.d = d;
        wb_q.push_back(w);
    endtask

    // Memory responder: asserts ready after wait_cfg idle request cycles per beat.
    initial begin
        int cnt;
        cnt = 0;
        bus.mem_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || !bus.mem_req_o) begin
                bus.mem_ready_i = 1'b0;
                cnt = 0;
            end else begin
                if (bus.mem_ready_i) cnt = 0;
                bus.mem_ready_i = (cnt >= wait_cfg);
                cnt++;
            end
        end
    end

    // Monitor: request stability, accepted beats and writeback pulses.
    initial begin
        logic        p_req, p_rdy, p_we;
        logic [31:0] p_addr, p_wd;
        logic [3:0]  p_be;
        beat_t       eb;
        wb_t         ew;
        p_req = 1'b0; p_rdy = 1'b0; p_we = 1'b0; p_addr = '0; p_wd = '0; p_be = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                p_req = 1'b0;
                p_rdy = 1'b0;
            end else begin
                if (bus.mem_req_o && p_req && !p_rdy) begin
                    check("hold_addr", bus.mem_addr_o, p_addr);
                    check("hold_be", 32'(bus.mem_byte_en_o), 32'(p_be));
                    check("hold_we", 32'(bus.mem_we_o), 32'(p_we));
                    check("hold_wdata", bus.mem_wdata_o, p_wd);
                end
                if (bus.mem_req_o && bus.mem_ready_i) begin
                    check("beat_expected", 32'(beat_q.size() != 0), 32'd1);
                    if (beat_q.size() != 0) begin
                        eb = beat_q.pop_front();
                        check("beat_addr", bus.mem_addr_o, eb.addr);
                        check("beat_we", 32'(bus.mem_we_o), 32'(eb.we));
                        check("beat_be", 32'(bus.mem_byte_en_o), 32'(eb.be));
                        if (eb.we) check("beat_wdata", bus.mem_wdata_o, eb.wd);
                        if (eb.chk_rr) check("beat_rf_reg", 32'(bus.rf_read_reg_o), 32'(eb.rr));
                    end
                end
                if (bus.wb_valid_o) begin
                    check("wb_expected", 32'(wb_q.size() != 0), 32'd1);
                    if (wb_q.size() != 0) begin
                        ew = wb_q.pop_front();
                        check("wb_reg", 32'(bus.wb_reg_o), 32'(ew.r));
                        check("wb_data", bus.wb_data_o, ew.d);
                    end
                end
                p_req  = bus.mem_req_o;
                p_rdy  = bus.mem_ready_i;
                p_we   = bus.mem_we_o;
                p_addr = bus.mem_addr_o;
                p_wd   = bus.mem_wdata_o;
                p_be   = bus.mem_byte_en_o;
            end
        end
    end

    task automatic issue(input mem_op_t op, input mem_size_t sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] dr, input logic [7:0] lst);
        @(posedge clk);
        #1;
        bus.ex_valid_i   = 1'b1;
        bus.mem_op_i     = op;
        bus.mem_size_i   = sz;
        bus.sign_ext_i   = sx;
        bus.address_i    = a;
        bus.store_data_i = d;
        bus.dest_reg_i   = dr;
        bus.reg_list_i   = lst;
        check("capture_stall_low", 32'(bus.stall_o), 32'd0);
        @(posedge clk);
        #1;
        bus.ex_valid_i = 1'b0;
        bus.mem_op_i   = MEM_NONE;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.stall_o && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_reached", 32'(bus.stall_o), 32'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 32'h0;
        rf[0] = 32'h0000_000A;
        rf[2] = 32'h0000_000B;
        rst = 1'b1;
        bus.ex_valid_i   = 1'b0;
        bus.mem_op_i     = MEM_NONE;
        bus.mem_size_i   = SIZE_BYTE;
        bus.sign_ext_i   = 1'b0;
        bus.address_i    = '0;
        bus.store_data_i = '0;
        bus.dest_reg_i   = '0;
        bus.reg_list_i   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", 32'(bus.mem_req_o), 32'd0);
        check("rst_stall", 32'(bus.stall_o), 32'd0);
        check("rst_wb_valid", 32'(bus.wb_valid_o), 32'd0);
        check("rst_addr", bus.mem_addr_o, 32'd0);
        check("rst_be", 32'(bus.mem_byte_en_o), 32'd0);
        check("rst_we", 32'(bus.mem_we_o), 32'd0);
        rst = 1'b0;

        // Signed byte load from lane 3, zero-wait memory: three-cycle latency.
        wait_cfg = 0;
        push_beat(32'h0000_1000, 1'b0, 4'b1000, 32'h0, 1'b0, 4'h0);
        push_wb(4'd3, 32'hFFFF_FF80);
        issue(MEM_LOAD, SIZE_BYTE, 1'b1, 32'h0000_1003, 32'h0, 4'd3, 8'h00);
        check("t1_req_cycle", 32'(bus.mem_req_o), 32'd1);
        check("t1_req_stall", 32'(bus.stall_o), 32'd1);
        @(posedge clk); #1;
        check("t1_wb_latency", 32'(bus.wb_valid_o), 32'd1);
        check("t1_stall_dropped", 32'(bus.stall_o), 32'd0);
        @(posedge clk); #1;
        check("t1_wb_one_cycle", 32'(bus.wb_valid_o), 32'd0);

        // Half store with three wait cycles; a new EX op during the stall must be ignored.
        wait_cfg = 3;
        push_beat(32'h0000_2000, 1'b1, 4'b1100, 32'hABCD_ABCD, 1'b0, 4'h0);
        issue(MEM_STORE, SIZE_HALF, 1'b0, 32'h0000_2002, 32'h1234_ABCD, 4'd0, 8'h00);
        for (int k = 0; k < 4; k++) begin
            check("t2_stall_held", 32'(bus.stall_o), 32'd1);
            if (k == 1) begin
                bus.ex_valid_i = 1'b1;
                bus.mem_op_i   = MEM_STORE;
                bus.address_i  = 32'h0000_9000;
            end
            if (k == 2) begin
                bus.ex_valid_i = 1'b0;
                bus.mem_op_i   = MEM_NONE;
            end
            @(posedge clk); #1;
        end
        check("t2_stall_released", 32'(bus.stall_o), 32'd0);
        wait_idle();

        // LDM r1, r4, r7 from 0x3000.
        wait_cfg = 0;
        push_beat(32'h0000_3000, 1'b0, 4'hF, 32'h0, 1'b0, 4'h0);
        push_beat(32'h0000_3004, 1'b0, 4'hF, 32'h0, 1'b0, 4'h0);
        push_beat(32'h0000_3008, 1'b0, 4'hF, 32'h0, 1'b0, 4'h0);
        push_wb(4'd1, 32'hDEAD_3000);
        push_wb(4'd4, 32'hDEAD_3004);
        push_wb(4'd7, 32'hDEAD_3008);
        issue(MEM_LOAD_MULT, SIZE_WORD, 1'b0, 32'h0000_3000, 32'h0, 4'd0, 8'b1001_0010);
        wait_idle();
        check("t3_req_low", 32'(bus.mem_req_o), 32'd0);

        // STM r0, r2 to 0x5000 with one wait cycle per beat.
        wait_cfg = 1;
        push_beat(32'h0000_5000, 1'b1, 4'hF, 32'h0000_000A, 1'b1, 4'd0);
        push_beat(32'h0000_5004, 1'b1, 4'hF, 32'h0000_000B, 1'b1, 4'd2);
        issue(MEM_STORE_MULT, SIZE_WORD, 1'b0, 32'h0000_5000, 32'h0, 4'd0, 8'b0000_0101);
        wait_idle();

        // Lane extraction variants.
        wait_cfg = 2;
        push_beat(32'h0000_7000, 1'b0, 4'b1100, 32'h0, 1'b0, 4'h0);
        push_wb(4'd5, 32'hFFFF_DEAD);
        issue(MEM_LOAD, SIZE_HALF, 1'b1, 32'h0000_7002, 32'h0, 4'd5, 8'h00);
        wait_idle();
        push_beat(32'h0000_7000, 1'b0, 4'b1100, 32'h0, 1'b0, 4'h0);
        push_wb(4'd8, 32'h0000_DEAD);
        issue(MEM_LOAD, SIZE_HALF, 1'b0, 32'h0000_7002, 32'h0, 4'd8, 8'h00);
        wait_idle();
        push_beat(32'h0000_7000, 1'b0, 4'b0010, 32'h0, 1'b0, 4'h0);
        push_wb(4'd6, 32'h0000_0070);
        issue(MEM_LOAD, SIZE_BYTE, 1'b0, 32'h0000_7001, 32'h0, 4'd6, 8'h00);
        wait_idle();

        // Word load at an unaligned address.
        wait_cfg = 0;
`ifdef MEM_ALIGN_CHECK_EN
        issue(MEM_LOAD, SIZE_WORD, 1'b0, 32'h0000_4002, 32'h0, 4'd9, 8'h00);
        check("t6_fault_pulse", 32'(align_fault), 32'd1);
        check("t6_fault_no_req", 32'(bus.mem_req_o), 32'd0);
        @(posedge clk); #1;
        check("t6_fault_cleared", 32'(align_fault), 32'd0);
        check("t6_fault_idle", 32'(bus.stall_o), 32'd0);
        check("t6_fault_still_no_req", 32'(bus.mem_req_o), 32'd0);
`else
        push_beat(32'h0000_4000, 1'b0, 4'hF, 32'h0, 1'b0, 4'h0);
        push_wb(4'd9, 32'hDEAD_4000);
        issue(MEM_LOAD, SIZE_WORD, 1'b0, 32'h0000_4002, 32'h0, 4'd9, 8'h00);
`endif
        wait_idle();

        // LDM whose addresses wrap past the top of the address space.
        push_beat(32'hFFFF_FFF8, 1'b0, 4'hF, 32'h0, 1'b0, 4'h0);
        push_beat(32'hFFFF_FFFC, 1'b0, 4'hF, 32'h0, 1'b0, 4'h0);
        push_beat(32'h0000_0000, 1'b0, 4'hF, 32'h0, 1'b0, 4'h0);
        push_wb(4'd0, 32'h2152_FFF8);
        push_wb(4'd1, 32'h2152_FFFC);
        push_wb(4'd2, 32'hDEAD_0000);
        issue(MEM_LOAD_MULT, SIZE_WORD, 1'b0, 32'hFFFF_FFF8, 32'h0, 4'd0, 8'b0000_0111);
        wait_idle();

        // Empty register list: no access, no stall.
        issue(MEM_LOAD_MULT, SIZE_WORD, 1'b0, 32'h0000_3000, 32'h0, 4'd0, 8'h00);
        for (int k = 0; k < 3; k++) begin
            check("t8_empty_no_req", 32'(bus.mem_req_o), 32'd0);
            check("t8_empty_no_stall", 32'(bus.stall_o), 32'd0);
            @(posedge clk); #1;
        end

        // Reset during an LDM after the first beat has been written back.
        push_beat(32'h0000_6000, 1'b0, 4'hF, 32'h0, 1'b0, 4'h0);
        push_beat(32'h0000_6004, 1'b0, 4'hF, 32'h0, 1'b0, 4'h0);
        push_wb(4'd0, 32'hDEAD_6000);
        issue(MEM_LOAD_MULT, SIZE_WORD, 1'b0, 32'h0000_6000, 32'h0, 4'd0, 8'b0000_1111);
        @(posedge clk); #1;
        check("t9_first_wb", 32'(bus.wb_valid_o), 32'd1);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        check("t9_rst_req_drop", 32'(bus.mem_req_o), 32'd0);
        check("t9_rst_stall_drop", 32'(bus.stall_o), 32'd0);
        check("t9_rst_wb_low", 32'(bus.wb_valid_o), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("t9_no_wb_in_rst", 32'(bus.wb_valid_o), 32'd0);
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("t9_no_wb_after_rst", 32'(bus.wb_valid_o), 32'd0);
            check("t9_idle_after_rst", 32'(bus.mem_req_o), 32'd0);
        end

        check("beat_q_drained", 32'(beat_q.size()), 32'd0);
        check("wb_q_drained", 32'(wb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
